// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding, wait counter width and a byte-parity helper.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Even parity: bit i makes byte i plus its parity bit hold an even count of ones.
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^w[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for stores (enables and
// replicated data) and lane extract plus sign/zero extension for loads.
// Ports: offset/size/unsigned_ld/wdata/rword in; misalign/be/wlanes/load out.
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] load
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx_b;
  logic        sx_h;

  assign shifted = rword >> {offset, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = offset[1] ? rword[31:16] : rword[15:0];
  assign sx_b    = ~unsigned_ld & byte_v[7];
  assign sx_h    = ~unsigned_ld & half_v[15];

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wlanes   = wdata;
    load     = '0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        be     = 4'b0001 << offset;
        wlanes = {4{wdata[7:0]}};
        load   = {{24{sx_b}}, byte_v};
      end
      (size == SZ_HALF): begin
        misalign = offset[0];
        be       = offset[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata[15:0]}};
        load     = {{16{sx_h}}, half_v};
      end
      (size == SZ_WORD): begin
        misalign = (offset != 2'b00);
        be       = 4'b1111;
        load     = rword;
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) begin
      be   = 4'b0000;
      load = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated load/store responder over a word array.
// Ports: clk, reset(async high), req/we/size/unsigned_ld/addr/wdata in;
// busy/ready/rdata/misalign/parity_err out. DMEM_PARITY_EN adds byte parity.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [31:0] mem [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // In IDLE the live inputs drive the datapath so a zero-wait request
  // can respond straight from the accept edge.
  logic              idle;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;

  assign idle     = (state == ST_IDLE);
  assign op_we    = idle ? we          : we_q;
  assign op_size  = idle ? size        : size_q;
  assign op_uns   = idle ? unsigned_ld : uns_q;
  assign op_addr  = idle ? addr        : addr_q;
  assign op_wdata = idle ? wdata       : wdata_q;

  logic [ADDR_W-3:0] idx;
  logic [31:0]       rword;
  logic              al_mis;
  logic [3:0]        al_be;
  logic [31:0]       al_wl;
  logic [31:0]       al_load;

  assign idx   = op_addr[ADDR_W-1:2];
  assign rword = mem[idx];

  dmem_lane_align u_align (
    .offset      (op_addr[1:0]),
    .size        (op_size),
    .unsigned_ld (op_uns),
    .wdata       (op_wdata),
    .rword       (rword),
    .misalign    (al_mis),
    .be          (al_be),
    .wlanes      (al_wl),
    .load        (al_load)
  );

  logic        enter_resp;
  logic        store_en;
  logic [31:0] new_word;
  logic        par_bad;
  logic        resp_par;
  logic [31:0] resp_data;

  assign enter_resp = (idle && req && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (cnt == '0));
  assign store_en   = enter_resp && op_we && !al_mis && !reset;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      new_word[i*8 +: 8] = al_be[i] ? al_wl[i*8 +: 8] : rword[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[idx] <= new_word;
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] mem_par [DEPTH];
  logic [3:0] new_par;

  assign new_par = byte_parity(new_word);
  assign par_bad = |(mem_par[idx] ^ byte_parity(rword));

  // Only written lanes refresh their parity bit; other lanes keep theirs.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (al_be[i]) begin
          mem_par[idx][i] <= new_par[i];
        end
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  assign resp_par  = !op_we && !al_mis && par_bad;
  assign resp_data = op_we ? 32'h0 : al_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      rdata      <= '0;
      misalign   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= unsigned_ld;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              busy  <= 1'b1;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          ready      <= 1'b0;
          rdata      <= '0;
          misalign   <= 1'b0;
          parity_err <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        ready      <= 1'b1;
        rdata      <= resp_data;
        misalign   <= al_mis;
        parity_err <= resp_par;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder (WAIT_STATES=2).
// Table of load/store vectors plus reset, back-to-back and parity sequences.
module tb_data_mem_responder;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        misalign;
  logic        parity_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .ready       (ready),
    .rdata       (rdata),
    .misalign    (misalign),
    .parity_err  (parity_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [1:0] s,
                              input logic u, input logic [9:0] a,
                              input logic [31:0] d, input logic [31:0] e,
                              input logic m);
    vec_t v;
    v.we = w; v.size = s; v.uns = u; v.addr = a;
    v.wdata = d; v.exp_rd = e; v.exp_mis = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents one request, waits (bounded) for ready and captures the response.
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [9:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd,
                       output logic mis, output logic pe,
                       output logic busy_ok);
    @(negedge clk);
    req = 1'b1; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; rd = 32'hx; mis = 1'bx; pe = 1'bx; busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k; rd = rdata; mis = misalign; pe = parity_err;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic run(input string nm, input logic w, input logic [1:0] s,
                     input logic u, input logic [9:0] a, input logic [31:0] d,
                     input logic [31:0] e, input logic m, input logic p);
    int lat;
    logic [31:0] rd;
    logic mis, pe, bok;
    issue(w, s, u, a, d, lat, rd, mis, pe, bok);
    chk({nm, " latency"}, lat, 3);
    chk({nm, " busy"}, {31'b0, bok}, 1);
    chk({nm, " rdata"}, rd, e);
    chk({nm, " misalign"}, {31'b0, mis}, {31'b0, m});
    chk({nm, " parity"}, {31'b0, pe}, {31'b0, p});
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = W;
    unsigned_ld = 1'b0; addr = '0; wdata = '0;

    tbl.push_back(mk(1, W, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0));
    tbl.push_back(mk(0, W, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(1, B, 0, 10'h013, 32'h12345680, 32'h0,        0));
    tbl.push_back(mk(0, B, 0, 10'h013, 32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mk(0, B, 1, 10'h013, 32'h0,        32'h00000080, 0));
    tbl.push_back(mk(0, W, 0, 10'h010, 32'h0,        32'h80ADBEEF, 0));
    tbl.push_back(mk(0, H, 0, 10'h011, 32'h0,        32'h0,        1));
    tbl.push_back(mk(0, W, 0, 10'h010, 32'h0,        32'h80ADBEEF, 0));
    tbl.push_back(mk(0, H, 0, 10'h012, 32'h0,        32'hFFFF80AD, 0));
    tbl.push_back(mk(0, H, 1, 10'h012, 32'h0,        32'h000080AD, 0));
    tbl.push_back(mk(0, H, 0, 10'h010, 32'h0,        32'hFFFFBEEF, 0));
    tbl.push_back(mk(0, B, 1, 10'h011, 32'h0,        32'h000000BE, 0));
    tbl.push_back(mk(0, B, 0, 10'h011, 32'h0,        32'hFFFFFFBE, 0));
    tbl.push_back(mk(0, R, 0, 10'h010, 32'h0,        32'h0,        1));
    tbl.push_back(mk(1, W, 0, 10'h012, 32'h11111111, 32'h0,        1));
    tbl.push_back(mk(0, W, 0, 10'h010, 32'h0,        32'h80ADBEEF, 0));
    tbl.push_back(mk(1, W, 0, 10'h014, 32'h00000000, 32'h0,        0));
    tbl.push_back(mk(1, H, 0, 10'h016, 32'hFFFFABCD, 32'h0,        0));
    tbl.push_back(mk(0, W, 0, 10'h014, 32'h0,        32'hABCD0000, 0));
    tbl.push_back(mk(0, B, 0, 10'h015, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, B, 0, 10'h014, 32'hFFFFFF7F, 32'h0,        0));
    tbl.push_back(mk(0, B, 0, 10'h014, 32'h0,        32'h0000007F, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst ready", {31'b0, ready}, 0);
    chk("rst rdata", rdata, 0);
    chk("rst misalign", {31'b0, misalign}, 0);
    chk("rst parity", {31'b0, parity_err}, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      run($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns,
          tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_mis, 1'b0);
    end

    // req held high: accepts only from IDLE, one response every 4 cycles.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = W; unsigned_ld = 1'b0; addr = 10'h010;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("hold ready k%0d", k), {31'b0, ready},
          {31'b0, (k % 4) == 3});
      chk($sformatf("hold busy k%0d", k), {31'b0, busy},
          {31'b0, ((k % 4) == 1) || ((k % 4) == 2)});
      if ((k % 4) == 3) chk($sformatf("hold rdata k%0d", k), rdata,
                            32'h80ADBEEF);
    end
    req = 1'b0;

    // Reset during WAIT aborts the store.
    run("pre020", 1, W, 0, 10'h020, 32'hCAFEF00D, 32'h0, 0, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = W; addr = 10'h020; wdata = 32'h12345678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("wait busy", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("wrst busy", {31'b0, busy}, 0);
    chk("wrst ready", {31'b0, ready}, 0);
    chk("wrst rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    run("ld020", 0, W, 0, 10'h020, 32'h0, 32'hCAFEF00D, 0, 0);

    // Reset during RESP: store already in the array, ready drops at once.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = W; addr = 10'h024; wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 req = 1'b0;
    begin
      int seen = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (ready) begin seen = k; break; end
      end
      chk("resp latency", seen, 3);
    end
    reset = 1'b1;
    #1;
    chk("rrst ready", {31'b0, ready}, 0);
    chk("rrst busy", {31'b0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    run("ld024", 0, W, 0, 10'h024, 32'h0, 32'h0BADF00D, 0, 0);

`ifdef DMEM_PARITY_EN
    dut.mem_par[4] = dut.mem_par[4] ^ 4'b0100;
    run("par on", 0, W, 0, 10'h010, 32'h0, 32'h80ADBEEF, 0, 1);
    run("par byte", 0, B, 1, 10'h011, 32'h0, 32'h000000BE, 0, 1);
`else
    run("par off", 0, W, 0, 10'h010, 32'h0, 32'h80ADBEEF, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
